// File: rtl/ft245_fifo_bridge.sv
// FT245 asynchronous-FIFO bridge: RX/TX byte FIFOs with valid/ready streams on the user side
// and a strobe sequencer on the chip side, with pin timing derived from nanosecond parameters.
module ft245_fifo_bridge #(
   parameter int CLOCK_PERIOD_NS  = 10,
   parameter int T_RD_ACTIVE_NS   = 30,
   parameter int T_RD_INACTIVE_NS = 14,
   parameter int T_WR_SETUP_NS    = 5,
   parameter int T_WR_ACTIVE_NS   = 30,
   parameter int RX_DEPTH         = 16,
   parameter int TX_DEPTH         = 16,
   parameter int ARB_MODE         = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [7:0]                      rx_data_245,
   input  logic                            rxf_245,
   output logic                            rd_245,
   output logic [7:0]                      tx_data_245,
   output logic                            tx_oe_245,
   input  logic                            txe_245,
   output logic                            wr_245,
   output logic [7:0]                      rx_data,
   output logic                            rx_valid,
   input  logic                            rx_ready,
   input  logic [7:0]                      tx_data,
   input  logic                            tx_valid,
   output logic                            tx_ready,
   output logic [$clog2(RX_DEPTH+1)-1:0]   rx_level,
   output logic [$clog2(TX_DEPTH+1)-1:0]   tx_level
);

   localparam int RXL_W = $clog2(RX_DEPTH + 1);
   localparam int TXL_W = $clog2(TX_DEPTH + 1);
   localparam int RXP_W = $clog2(RX_DEPTH);
   localparam int TXP_W = $clog2(TX_DEPTH);

   function automatic logic [15:0] ns_to_cnt(input int t_ns);
      int c;
      c = (t_ns + CLOCK_PERIOD_NS - 1) / CLOCK_PERIOD_NS;
      if (c < 1) c = 1;
      return c[15:0];
   endfunction

   // Counters run 0..N-1, so each phase ends when the counter reaches N-1.
   localparam logic [15:0] LAST_RD  = ns_to_cnt(T_RD_ACTIVE_NS) - 16'd1;
   localparam logic [15:0] LAST_RDI = ns_to_cnt(T_RD_INACTIVE_NS) - 16'd1;
   localparam logic [15:0] LAST_SU  = ns_to_cnt(T_WR_SETUP_NS) - 16'd1;
   localparam logic [15:0] LAST_WR  = ns_to_cnt(T_WR_ACTIVE_NS) - 16'd1;

   localparam logic [RXL_W-1:0] RX_FULL = RXL_W'(RX_DEPTH);
   localparam logic [TXL_W-1:0] TX_FULL = TXL_W'(TX_DEPTH);

   typedef enum logic [2:0] {IDLE, RD_ACT, RD_INACT, WR_SU, WR_ACT, WR_HOLD} state_t;

   state_t             state_q, state_d;
   logic [15:0]        cnt_q, cnt_d;
   logic               rd_245_q, rd_245_d;
   logic               wr_245_q, wr_245_d;
   logic               tx_oe_q, tx_oe_d;
   logic [7:0]         tx_data_245_q, tx_data_245_d;
   logic               rr_tx_q, rr_tx_d;

   logic [7:0]         rx_mem_q [RX_DEPTH];
   logic [RXP_W-1:0]   rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
   logic [RXL_W-1:0]   rx_level_q, rx_level_d;
   logic [7:0]         tx_mem_q [TX_DEPTH];
   logic [TXP_W-1:0]   tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
   logic [TXL_W-1:0]   tx_level_q, tx_level_d;

   logic rx_push, rx_pop, tx_push, tx_pop;
   logic rd_req, wr_req, grant_rd, grant_wr;

   assign rd_245      = rd_245_q;
   assign wr_245      = wr_245_q;
   assign tx_oe_245   = tx_oe_q;
   assign tx_data_245 = tx_data_245_q;
   assign rx_data     = rx_mem_q[rx_rd_ptr_q];
   assign rx_valid    = (rx_level_q != '0);
   assign tx_ready    = (tx_level_q != TX_FULL);
   assign rx_level    = rx_level_q;
   assign tx_level    = tx_level_q;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rd_245_d      = rd_245_q;
      wr_245_d      = wr_245_q;
      tx_oe_d       = tx_oe_q;
      tx_data_245_d = tx_data_245_q;
      rr_tx_d       = rr_tx_q;
      rx_push       = 1'b0;
      tx_pop        = 1'b0;
      rd_req        = !rxf_245 && (rx_level_q != RX_FULL);
      wr_req        = !txe_245 && (tx_level_q != '0);
      // rr_tx_q marks which side wins the next conflict in round-robin mode.
      grant_rd      = rd_req && (!wr_req || (ARB_MODE == 0) || !rr_tx_q);
      grant_wr      = wr_req && !grant_rd;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (grant_rd) begin
               rd_245_d = 1'b0;
               rr_tx_d  = 1'b1;
               state_d  = RD_ACT;
            end else if (grant_wr) begin
               tx_pop        = 1'b1;
               tx_data_245_d = tx_mem_q[tx_rd_ptr_q];
               tx_oe_d       = 1'b1;
               rr_tx_d       = 1'b0;
               state_d       = WR_SU;
            end
         end
         RD_ACT: begin
            if (cnt_q == LAST_RD) begin
               rx_push  = 1'b1;
               rd_245_d = 1'b1;
               cnt_d    = '0;
               state_d  = RD_INACT;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RD_INACT: begin
            if (cnt_q == LAST_RDI) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         WR_SU: begin
            if (cnt_q == LAST_SU) begin
               wr_245_d = 1'b0;
               cnt_d    = '0;
               state_d  = WR_ACT;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         WR_ACT: begin
            if (cnt_q == LAST_WR) begin
               wr_245_d = 1'b1;
               cnt_d    = '0;
               state_d  = WR_HOLD;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         WR_HOLD: begin
            tx_oe_d = 1'b0;
            state_d = IDLE;
         end
         default: begin
            rd_245_d = 1'b1;
            wr_245_d = 1'b1;
            tx_oe_d  = 1'b0;
            cnt_d    = '0;
            state_d  = IDLE;
         end
      endcase
   end

   always_comb begin
      rx_pop      = rx_valid && rx_ready;
      tx_push     = tx_valid && tx_ready;
      rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + RXP_W'(1) : rx_wr_ptr_q;
      rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + RXP_W'(1) : rx_rd_ptr_q;
      tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + TXP_W'(1) : tx_wr_ptr_q;
      tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + TXP_W'(1) : tx_rd_ptr_q;
      rx_level_d  = rx_level_q;
      tx_level_d  = tx_level_q;
      case ({rx_push, rx_pop})
         2'b10:   rx_level_d = rx_level_q + RXL_W'(1);
         2'b01:   rx_level_d = rx_level_q - RXL_W'(1);
         default: rx_level_d = rx_level_q;
      endcase
      case ({tx_push, tx_pop})
         2'b10:   tx_level_d = tx_level_q + TXL_W'(1);
         2'b01:   tx_level_d = tx_level_q - TXL_W'(1);
         default: tx_level_d = tx_level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         rd_245_q      <= 1'b1;
         wr_245_q      <= 1'b1;
         tx_oe_q       <= 1'b0;
         tx_data_245_q <= '0;
         rr_tx_q       <= 1'b0;
         rx_wr_ptr_q   <= '0;
         rx_rd_ptr_q   <= '0;
         rx_level_q    <= '0;
         tx_wr_ptr_q   <= '0;
         tx_rd_ptr_q   <= '0;
         tx_level_q    <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rd_245_q      <= rd_245_d;
         wr_245_q      <= wr_245_d;
         tx_oe_q       <= tx_oe_d;
         tx_data_245_q <= tx_data_245_d;
         rr_tx_q       <= rr_tx_d;
         rx_wr_ptr_q   <= rx_wr_ptr_d;
         rx_rd_ptr_q   <= rx_rd_ptr_d;
         rx_level_q    <= rx_level_d;
         tx_wr_ptr_q   <= tx_wr_ptr_d;
         tx_rd_ptr_q   <= tx_rd_ptr_d;
         tx_level_q    <= tx_level_d;
      end
   end

   // Storage carries no reset; occupancy and pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (rx_push && !rst) rx_mem_q[rx_wr_ptr_q] <= rx_data_245;
      if (tx_push && !rst) tx_mem_q[tx_wr_ptr_q] <= tx_data;
   end

endmodule
